// File: rtl/acu_sequencer.sv
// acu_sequencer: round-robin arbiter and load sequencer for the 16-bit ACU.
// A granted requester's address is written through the ACU's byte interface
// (low byte, then high byte unless the ACU already holds it), after which
// acu_oe is held for HOLD cycles and the requester gets a done pulse.
module acu_sequencer #(
    parameter int HOLD = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic [15:0] addr0,
    output logic        gnt0,
    output logic        done0,
    input  logic        req1,
    input  logic [15:0] addr1,
    output logic        gnt1,
    output logic        done1,
    output logic [7:0]  acu_d,
    output logic        acu_wl,
    output logic        acu_wh,
    output logic        acu_oe,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        DRV  = 2'd3
    } state_t;

    // Final value of the hold counter; done is raised in the cycle it is reached.
    localparam logic [3:0] CNT_LAST = 4'(HOLD - 1);

    state_t      state;
    logic [3:0]  cnt;
    logic [15:0] cap;
    logic [7:0]  hi_shadow;
    logic        hi_valid;
    logic        last;
    logic        owner;

    logic        any_req;
    logic        pick;
    logic        skip_hi;
    logic [3:0]  cnt_nxt;

    // Arbitration and next-step decisions derived from current requests and state.
    always_comb begin
        any_req = req0 | req1;
        // On a tie the requester that did not win last time is chosen.
        pick    = (req0 && req1) ? ~last : req1;
        skip_hi = hi_valid && (hi_shadow == cap[15:8]);
        cnt_nxt = cnt + 4'd1;
    end

    // Sequencer FSM; every output is registered alongside the state it belongs to.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            hi_valid <= 1'b0;
            last     <= 1'b1;
            owner    <= 1'b0;
            gnt0     <= 1'b0;
            gnt1     <= 1'b0;
            done0    <= 1'b0;
            done1    <= 1'b0;
            acu_d    <= 8'h00;
            acu_wl   <= 1'b0;
            acu_wh   <= 1'b0;
            acu_oe   <= 1'b0;
            busy     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        state  <= LO;
                        owner  <= pick;
                        last   <= pick;
                        gnt0   <= ~pick;
                        gnt1   <= pick;
                        cap    <= pick ? addr1 : addr0;
                        acu_d  <= pick ? addr1[7:0] : addr0[7:0];
                        acu_wl <= 1'b1;
                        busy   <= 1'b1;
                    end
                end
                LO: begin
                    acu_wl <= 1'b0;
                    cnt    <= 4'd0;
                    if (skip_hi) begin
                        // ACU already holds this high byte: go straight to drive.
                        state  <= DRV;
                        acu_d  <= 8'h00;
                        acu_oe <= 1'b1;
                        done0  <= ~owner && (CNT_LAST == 4'd0);
                        done1  <= owner && (CNT_LAST == 4'd0);
                    end else begin
                        state  <= HI;
                        acu_d  <= cap[15:8];
                        acu_wh <= 1'b1;
                    end
                end
                HI: begin
                    acu_wh    <= 1'b0;
                    hi_shadow <= cap[15:8];
                    hi_valid  <= 1'b1;
                    state     <= DRV;
                    acu_d     <= 8'h00;
                    acu_oe    <= 1'b1;
                    cnt       <= 4'd0;
                    done0     <= ~owner && (CNT_LAST == 4'd0);
                    done1     <= owner && (CNT_LAST == 4'd0);
                end
                DRV: begin
                    if (cnt == CNT_LAST) begin
                        state  <= IDLE;
                        cnt    <= 4'd0;
                        acu_oe <= 1'b0;
                        gnt0   <= 1'b0;
                        gnt1   <= 1'b0;
                        done0  <= 1'b0;
                        done1  <= 1'b0;
                        busy   <= 1'b0;
                    end else begin
                        cnt   <= cnt_nxt;
                        done0 <= ~owner && (cnt_nxt == CNT_LAST);
                        done1 <= owner && (cnt_nxt == CNT_LAST);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_acu_sequencer.sv
// Testbench for acu_sequencer: a HOLD=2 instance with a scoreboard of expected
// transactions and a behavioural ACU register, plus a HOLD=1 instance.
module tb_acu_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Instance A (HOLD=2)
    logic        a_req0 = 1'b0, a_req1 = 1'b0;
    logic [15:0] a_addr0 = 16'h0, a_addr1 = 16'h0;
    logic        a_gnt0, a_gnt1, a_done0, a_done1, a_wl, a_wh, a_oe, a_busy;
    logic [7:0]  a_d;

    // Instance B (HOLD=1)
    logic        b_req0 = 1'b0, b_req1 = 1'b0;
    logic [15:0] b_addr0 = 16'h0, b_addr1 = 16'h0;
    logic        b_gnt0, b_gnt1, b_done0, b_done1, b_wl, b_wh, b_oe, b_busy;
    logic [7:0]  b_d;

    acu_sequencer #(.HOLD(2)) dut_a (
        .clk(clk), .rst(rst),
        .req0(a_req0), .addr0(a_addr0), .gnt0(a_gnt0), .done0(a_done0),
        .req1(a_req1), .addr1(a_addr1), .gnt1(a_gnt1), .done1(a_done1),
        .acu_d(a_d), .acu_wl(a_wl), .acu_wh(a_wh), .acu_oe(a_oe), .busy(a_busy)
    );

    acu_sequencer #(.HOLD(1)) dut_b (
        .clk(clk), .rst(rst),
        .req0(b_req0), .addr0(b_addr0), .gnt0(b_gnt0), .done0(b_done0),
        .req1(b_req1), .addr1(b_addr1), .gnt1(b_gnt1), .done1(b_done1),
        .acu_d(b_d), .acu_wl(b_wl), .acu_wh(b_wh), .acu_oe(b_oe), .busy(b_busy)
    );

    // Behavioural ACU registers, reset from the same net as the sequencers.
    logic [15:0] a_q, b_q;
    always @(posedge clk) begin
        if (rst) begin
            a_q <= 16'h0;
            b_q <= 16'h0;
        end else begin
            if (a_wl) a_q[7:0]  <= a_d;
            if (a_wh) a_q[15:8] <= a_d;
            if (b_wl) b_q[7:0]  <= b_d;
            if (b_wh) b_q[15:8] <= b_d;
        end
    end

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit          id;
        logic [15:0] addr;
        bit          wh;
    } exp_t;
    exp_t sbq[$];

    // Scoreboard monitor for instance A: protocol exclusivity every cycle,
    // and on each done pulse the expected requester, ACU contents and whether
    // the high byte was written.
    bit saw_wh = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            saw_wh = 1'b0;
        end else begin
            if (!a_busy) saw_wh = 1'b0;
            if (a_wh) saw_wh = 1'b1;
            checks++;
            if ((a_gnt0 && a_gnt1) || ((int'(a_wl) + int'(a_wh) + int'(a_oe)) > 1)) begin
                errors++;
                $display("FAIL exclusivity: gnt=%b%b wl/wh/oe=%b%b%b required at most one each",
                         a_gnt1, a_gnt0, a_wl, a_wh, a_oe);
            end
            if (a_done0 || a_done1) begin
                checks++;
                if (sbq.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_done: done=%b%b with no transaction expected",
                             a_done1, a_done0);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    if (a_done0 && a_done1) begin
                        errors++;
                        $display("FAIL done_both: done1=1 done0=1 required one");
                    end else if (a_done1 !== e.id || a_q !== e.addr || saw_wh !== e.wh) begin
                        errors++;
                        $display("FAIL sb_txn: id=%0d q=%h wh=%b required id=%0d q=%h wh=%b",
                                 a_done1, a_q, saw_wh, e.id, e.addr, e.wh);
                    end
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if ({a_gnt0, a_gnt1, a_done0, a_done1, a_wl, a_wh, a_oe, a_busy, a_d} !== 16'h0) begin
            errors++;
            $display("FAIL reset_a: outs=%h required 0000",
                     {a_gnt0, a_gnt1, a_done0, a_done1, a_wl, a_wh, a_oe, a_busy, a_d});
        end
        checks++;
        if ({b_gnt0, b_gnt1, b_done0, b_done1, b_wl, b_wh, b_oe, b_busy, b_d} !== 16'h0) begin
            errors++;
            $display("FAIL reset_b: outs=%h required 0000",
                     {b_gnt0, b_gnt1, b_done0, b_done1, b_wl, b_wh, b_oe, b_busy, b_d});
        end
        rst = 1'b0;
    endtask

    task automatic test_full_load;
        a_req0 = 1'b1; a_addr0 = 16'h4064;
        sbq.push_back('{id: 1'b0, addr: 16'h4064, wh: 1'b1});
        tick();
        a_req0 = 1'b0;
        checks++;
        if (a_d !== 8'h64 || a_wl !== 1'b1 || a_gnt0 !== 1'b1 || a_busy !== 1'b1) begin
            errors++;
            $display("FAIL full_lo: d=%h wl=%b gnt0=%b busy=%b required 64 1 1 1", a_d, a_wl, a_gnt0, a_busy);
        end
        tick();
        checks++;
        if (a_d !== 8'h40 || a_wh !== 1'b1) begin
            errors++;
            $display("FAIL full_hi: d=%h wh=%b required 40 1", a_d, a_wh);
        end
        tick();
        checks++;
        if (a_oe !== 1'b1 || a_d !== 8'h00 || a_done0 !== 1'b0) begin
            errors++;
            $display("FAIL full_drv1: oe=%b d=%h done0=%b required 1 00 0", a_oe, a_d, a_done0);
        end
        tick();
        checks++;
        if (a_oe !== 1'b1 || a_done0 !== 1'b1 || a_q !== 16'h4064) begin
            errors++;
            $display("FAIL full_drv2: oe=%b done0=%b q=%h required 1 1 4064", a_oe, a_done0, a_q);
        end
        tick();
        checks++;
        if (a_gnt0 !== 1'b0 || a_busy !== 1'b0 || a_oe !== 1'b0 || a_done0 !== 1'b0) begin
            errors++;
            $display("FAIL full_idle: gnt0=%b busy=%b oe=%b done0=%b required 0 0 0 0",
                     a_gnt0, a_busy, a_oe, a_done0);
        end
    endtask

    task automatic test_skip;
        a_req0 = 1'b1; a_addr0 = 16'h4020;
        sbq.push_back('{id: 1'b0, addr: 16'h4020, wh: 1'b0});
        tick();
        a_req0 = 1'b0;
        checks++;
        if (a_d !== 8'h20 || a_wl !== 1'b1) begin
            errors++;
            $display("FAIL skip_lo: d=%h wl=%b required 20 1", a_d, a_wl);
        end
        tick();
        checks++;
        if (a_oe !== 1'b1 || a_wh !== 1'b0) begin
            errors++;
            $display("FAIL skip_drv: oe=%b wh=%b required 1 0", a_oe, a_wh);
        end
        tick();
        checks++;
        if (a_done0 !== 1'b1 || a_q !== 16'h4020) begin
            errors++;
            $display("FAIL skip_done: done0=%b q=%h required 1 4020", a_done0, a_q);
        end
        tick();
        checks++;
        if (a_busy !== 1'b0) begin
            errors++;
            $display("FAIL skip_idle: busy=%b required 0", a_busy);
        end
        // Different high byte: the high-byte write must happen again.
        a_req0 = 1'b1; a_addr0 = 16'h2020;
        sbq.push_back('{id: 1'b0, addr: 16'h2020, wh: 1'b1});
        tick();
        a_req0 = 1'b0;
        tick();
        checks++;
        if (a_wh !== 1'b1 || a_d !== 8'h20) begin
            errors++;
            $display("FAIL noskip_hi: wh=%b d=%h required 1 20", a_wh, a_d);
        end
        tick();
        tick();
        tick();
    endtask

    task automatic test_round_robin;
        int n;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        a_req0 = 1'b1; a_req1 = 1'b1;
        a_addr0 = 16'h1111; a_addr1 = 16'h2222;
        for (int k = 0; k < 4; k++)
            sbq.push_back('{id: k[0], addr: (k[0] ? 16'h2222 : 16'h1111), wh: 1'b1});
        for (int k = 0; k < 4; k++) begin
            n = 0;
            while (!a_busy && n < 20) begin
                tick();
                n++;
            end
            checks++;
            if (!a_busy || (k > 0 && n != 1)) begin
                errors++;
                $display("FAIL rr_gap%0d: idle cycles=%0d busy=%b required 1 idle cycle then busy", k, n, a_busy);
            end
            checks++;
            if (a_gnt0 !== ~k[0] || a_gnt1 !== k[0]) begin
                errors++;
                $display("FAIL rr_order%0d: gnt1/gnt0=%b%b required %b%b", k, a_gnt1, a_gnt0, k[0], ~k[0]);
            end
            n = 0;
            while (a_busy && n < 20) begin
                tick();
                n++;
            end
            checks++;
            if (a_busy || n != 4) begin
                errors++;
                $display("FAIL rr_len%0d: busy cycles=%0d required 4", k, n);
            end
        end
        a_req0 = 1'b0; a_req1 = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid;
        a_req1 = 1'b1; a_addr1 = 16'h4020;
        tick();
        a_req1 = 1'b0;
        tick();
        checks++;
        if (a_wh !== 1'b1) begin
            errors++;
            $display("FAIL abort_hi: wh=%b required 1", a_wh);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({a_gnt0, a_gnt1, a_done0, a_done1, a_wl, a_wh, a_oe, a_busy, a_d} !== 16'h0) begin
            errors++;
            $display("FAIL abort_outs: outs=%h required 0000",
                     {a_gnt0, a_gnt1, a_done0, a_done1, a_wl, a_wh, a_oe, a_busy, a_d});
        end
        a_req1 = 1'b1; a_addr1 = 16'h4020;
        sbq.push_back('{id: 1'b1, addr: 16'h4020, wh: 1'b1});
        tick();
        a_req1 = 1'b0;
        tick();
        checks++;
        if (a_wh !== 1'b1 || a_d !== 8'h40 || a_gnt1 !== 1'b1) begin
            errors++;
            $display("FAIL post_abort_hi: wh=%b d=%h gnt1=%b required 1 40 1", a_wh, a_d, a_gnt1);
        end
        tick();
        tick();
        tick();
    endtask

    task automatic test_req_drop;
        a_req1 = 1'b1; a_addr1 = 16'h5A3C;
        sbq.push_back('{id: 1'b1, addr: 16'h5A3C, wh: 1'b1});
        tick();
        a_req1 = 1'b0; a_addr1 = 16'hFFFF;
        tick();
        checks++;
        if (a_d !== 8'h5A || a_wh !== 1'b1) begin
            errors++;
            $display("FAIL drop_hi: d=%h wh=%b required 5a 1", a_d, a_wh);
        end
        tick();
        tick();
        checks++;
        if (a_done1 !== 1'b1 || a_q !== 16'h5A3C) begin
            errors++;
            $display("FAIL drop_done: done1=%b q=%h required 1 5a3c", a_done1, a_q);
        end
        tick();
    endtask

    task automatic test_hold1;
        b_req0 = 1'b1; b_addr0 = 16'h00FF;
        tick();
        b_req0 = 1'b0;
        checks++;
        if (b_d !== 8'hFF || b_wl !== 1'b1 || b_gnt0 !== 1'b1) begin
            errors++;
            $display("FAIL h1_lo: d=%h wl=%b gnt0=%b required ff 1 1", b_d, b_wl, b_gnt0);
        end
        tick();
        checks++;
        if (b_d !== 8'h00 || b_wh !== 1'b1 || b_oe !== 1'b0) begin
            errors++;
            $display("FAIL h1_hi: d=%h wh=%b oe=%b required 00 1 0", b_d, b_wh, b_oe);
        end
        tick();
        checks++;
        if (b_oe !== 1'b1 || b_done0 !== 1'b1 || b_q !== 16'h00FF) begin
            errors++;
            $display("FAIL h1_drv: oe=%b done0=%b q=%h required 1 1 00ff", b_oe, b_done0, b_q);
        end
        tick();
        checks++;
        if (b_oe !== 1'b0 || b_done0 !== 1'b0 || b_busy !== 1'b0 || b_gnt0 !== 1'b0) begin
            errors++;
            $display("FAIL h1_idle: oe=%b done0=%b busy=%b gnt0=%b required 0 0 0 0",
                     b_oe, b_done0, b_busy, b_gnt0);
        end
    endtask

    initial begin
        test_reset();
        test_full_load();
        test_skip();
        test_round_robin();
        test_reset_mid();
        test_req_drop();
        test_hold1();
        tick();
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: %0d transactions pending, required 0", sbq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
